// File: rtl/mux_scan_sel.sv
// N-channel registered mux with manual select and round-robin scan with per-channel dwell.
// Optional MUX_SCAN_SEL_SYNC_EN adds two-flop synchronisers on en/mode/sel.
module mux_scan_sel #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 1,
  parameter int SEL_W    = 2,
  parameter int DWELL_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] ch_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic [DWELL_W-1:0]        dwell,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          y_ch,
  output logic                      y_valid,
  output logic                      scan_wrap
);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  localparam logic [SEL_W:0]   NCH  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS-1);

  logic             en_c, mode_c;
  logic [SEL_W-1:0] sel_c;

`ifdef MUX_SCAN_SEL_SYNC_EN
  logic [1:0]            en_sq, mode_sq;
  logic [1:0][SEL_W-1:0] sel_sq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sq   <= '0;
      mode_sq <= '0;
      sel_sq  <= '0;
    end else begin
      en_sq   <= {en_sq[0], en};
      mode_sq <= {mode_sq[0], mode};
      sel_sq  <= {sel_sq[0], sel};
    end
  end

  assign en_c   = en_sq[1];
  assign mode_c = mode_sq[1];
  assign sel_c  = sel_sq[1];
`else
  assign en_c   = en;
  assign mode_c = mode;
  assign sel_c  = sel;
`endif

  state_t             st_q, st_d;
  logic               resume_q, resume_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d, cur_ptr;
  logic [DWELL_W-1:0] cnt_q, cnt_d, cur_cnt, term;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [SEL_W-1:0]   ych_q, ych_d;
  logic               vld_q, vld_d, wrap_q, wrap_d;
  logic               sel_ok, entry;

  function automatic logic [WIDTH-1:0] pick(input logic [SEL_W-1:0] idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (idx == SEL_W'(i)) r = ch_in[i*WIDTH +: WIDTH];
    return r;
  endfunction

  always_comb begin
    st_d     = !en_c ? IDLE : (mode_c ? SCAN : MANUAL);
    sel_ok   = {1'b0, sel_c} < NCH;
    // resume_q remembers that the last active mode was SCAN, so an en
    // drop-out resumes the dwell instead of reloading the pointer.
    entry    = (st_d == SCAN) && (st_q != SCAN) && !((st_q == IDLE) && resume_q);
    term     = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    cur_ptr  = entry ? (sel_ok ? sel_c : '0) : ptr_q;
    cur_cnt  = entry ? '0 : cnt_q;
    y_d      = y_q;
    ych_d    = ych_q;
    vld_d    = 1'b0;
    wrap_d   = 1'b0;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    resume_d = resume_q;
    case (st_d)
      MANUAL: begin
        y_d      = sel_ok ? pick(sel_c) : '0;
        ych_d    = sel_c;
        vld_d    = sel_ok;
        cnt_d    = '0;
        resume_d = 1'b0;
      end
      SCAN: begin
        // The entry edge is itself the first dwell cycle of the loaded channel.
        y_d      = pick(cur_ptr);
        ych_d    = cur_ptr;
        vld_d    = 1'b1;
        resume_d = 1'b1;
        ptr_d    = cur_ptr;
        if (cur_cnt == term) begin
          cnt_d  = '0;
          ptr_d  = (cur_ptr == LAST) ? '0 : cur_ptr + SEL_W'(1);
          wrap_d = (cur_ptr == LAST);
        end else begin
          cnt_d  = cur_cnt + DWELL_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      resume_q <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      ych_q    <= '0;
      vld_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      resume_q <= resume_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      ych_q    <= ych_d;
      vld_q    <= vld_d;
      wrap_q   <= wrap_d;
    end
  end

  assign y         = y_q;
  assign y_ch      = ych_q;
  assign y_valid   = vld_q;
  assign scan_wrap = wrap_q;

endmodule

// File: doc/mux_scan_sel.md
# mux_scan_sel

Parametrised N-channel registered multiplexer with manual select and an autonomous round-robin scan mode. Generalises the team's 4:1 single-bit selector to configurable channel count and data width. Adds a registered output with channel tag, valid flag and programmable per-channel dwell. Sits between the `ui_in` pin bank and the `uo_out` drivers in the top-level wrapper.

## Interface
- `CHANNELS`, default 4: number of input channels; must be at least 2.
- `WIDTH`, default 1: bits per channel.
- `SEL_W`, default 2: select/index width; must satisfy 2^`SEL_W` ≥ `CHANNELS`.
- `DWELL_W`, default 8: dwell counter width.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `en`  in  1: global enable; low freezes all state.
- `ch_in`  in  `CHANNELS*WIDTH`: channel data; channel i occupies bits [i*`WIDTH` +: `WIDTH`].
- `sel`  in  `SEL_W`: manual channel select.
- `mode`  in  1: 0 = manual, 1 = scan.
- `dwell`  in  `DWELL_W`: cycles spent per channel in scan mode; 0 is treated as 1.
- `y`  out  `WIDTH`: registered selected data.
- `y_ch`  out  `SEL_W`: index of the channel currently in `y`.
- `y_valid`  out  1: `y`/`y_ch` hold a legal sample taken this cycle.
- `scan_wrap`  out  1: one-cycle pulse when the scan pointer wraps from `CHANNELS`-1 to 0.

## Operation
- States: IDLE, MANUAL, SCAN. Reset enters IDLE.
- Transitions are evaluated every edge:
  - `en`=0 → IDLE.
  - `en`=1 and `mode`=0 → MANUAL.
  - `en`=1 and `mode`=1 → SCAN.
- IDLE:
  - `y` and `y_ch` hold their values.
  - `y_valid`=0 and `scan_wrap`=0.
  - Scan pointer `ptr` and dwell counter `cnt` are frozen.
- MANUAL, with `sel` < `CHANNELS`: `y` ← channel `sel`, `y_ch` ← `sel`, `y_valid` ← 1.
- MANUAL, with `sel` ≥ `CHANNELS`: `y` ← 0, `y_ch` ← `sel`, `y_valid` ← 0.
- MANUAL always clears `cnt`.
- SCAN, every edge: `y` ← channel `ptr`, `y_ch` ← `ptr`, `y_valid` ← 1.
  - `cnt` increments while below max(`dwell`,1)-1.
  - When `cnt` reaches that terminal value: `cnt` ← 0 and `ptr` advances by one.
  - When `ptr` advances from `CHANNELS`-1, it wraps to 0 and `scan_wrap` ← 1 on the same edge. `scan_wrap` is 0 on all other edges.
- Entering SCAN from MANUAL or IDLE:
  - `ptr` loads `sel` if `sel` < `CHANNELS`, otherwise 0.
  - `cnt` ← 0.
  - The entry edge itself samples channel `sel` (or 0) as in the SCAN rule.
- Leaving SCAN for MANUAL: follows `sel` from the next edge; `ptr` retains its value.
- A `dwell` change takes effect on the next terminal compare; `cnt` is not reset.
  - If new `dwell`-1 is below the current `cnt`, the counter keeps incrementing and wraps at 2^`DWELL_W`. This is allowed and is not an error.
- Arithmetic: `ptr` is `SEL_W` bits with explicit wrap at `CHANNELS`-1, never at 2^`SEL_W`. `cnt` is `DWELL_W` bits, unsigned.

## Timing
- Reset values: `y`=0, `y_ch`=0, `y_valid`=0, `scan_wrap`=0, `ptr`=0, `cnt`=0, state IDLE.
- Asynchronous reset mid-scan clears everything immediately. First output is one edge after `rst_n` deasserts, given `en`=1.
- Latency is 1 cycle from `ch_in`/`sel` to `y`/`y_ch`/`y_valid`, with no synchroniser (see Configuration).
- In SCAN with `dwell`=D≥1, each channel appears on `y_ch` for exactly D consecutive valid cycles.
- `scan_wrap` rises on the same edge that `ptr` becomes 0, so it coincides with the last sample of channel `CHANNELS`-1 in `y`.
- `en` falling mid-dwell: `cnt` is frozen. When `en` returns, the remaining dwell continues, unless `mode` changed.

## Configuration
- `MUX_SCAN_SEL_SYNC_EN`:
  - Defined: `sel`, `mode` and `en` each pass through a two-flop synchroniser, reset to 0, before use. Control-to-output latency becomes 3 cycles. The `ch_in` data path stays at 1 cycle.
  - Undefined: controls are used directly, with latency 1 cycle.

## Test plan
- Reset: assert `rst_n`=0 mid-scan → all outputs 0 immediately. Release with `en`=1, `mode`=0, `sel`=2, `ch_in`=4'b0100 → next edge `y`=1, `y_ch`=2, `y_valid`=1.
- Manual sweep: `sel`=0..3 with `ch_in`=4'b1010 → `y` = 0,1,0,1 one cycle later, `y_valid`=1 throughout.
- Out-of-range select: `CHANNELS`=3, `sel`=3 → `y`=0, `y_ch`=3, `y_valid`=0.
- Scan: `dwell`=2, entered with `sel`=1 → `y_ch` = 1,1,2,2,3,3,0,0. `scan_wrap` is high only on the edge where `y_ch` is last 3.
- `dwell`=0: behaves as `dwell`=1; `y_ch` steps every cycle and `scan_wrap` occurs every 4 cycles.
- Enable freeze: `en`=0 for 5 cycles mid-dwell with `dwell`=3 → `y`/`y_ch` held, `y_valid`=0. On `en`=1 the channel completes its remaining dwell count. With `MUX_SCAN_SEL_SYNC_EN` defined, every control response is delayed by 2 extra cycles.
